// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the fetch port and the
// data port, with a per-transaction timeout and a sticky error flag.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255,
  parameter bit D_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_valid,
  output logic          stall,
  output logic          err
);

  localparam int CW = $clog2(TIMEOUT + 1) + 1;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  state_t        state_q;
  logic          last_d_q;
  logic [CW-1:0] cnt_q;
  logic          mem_req_q, mem_we_q, if_ack_q, d_ack_q, err_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q, if_rdata_q, d_rdata_q;

  logic          grant_d_d;
  logic          expired_d;
  logic [DW-1:0] cap_d;

  // Data wins when it is the only requester or when fetch was the last contended grant.
  always_comb begin
    grant_d_d = d_req & (~if_req | ~last_d_q);
    expired_d = (cnt_q == CW'(TIMEOUT));
    cap_d     = mem_valid ? mem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_d_q    <= ~D_FIRST;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (if_req | d_req) begin
            mem_req_q <= 1'b1;
            cnt_q     <= '0;
            if (if_req & d_req) last_d_q <= grant_d_d;
            if (grant_d_d) begin
              state_q     <= BUSY_D;
              mem_addr_q  <= d_addr;
              mem_we_q    <= d_we;
              mem_wdata_q <= d_wdata;
            end else begin
              state_q     <= BUSY_I;
              mem_addr_q  <= if_addr;
              mem_we_q    <= 1'b0;
              mem_wdata_q <= '0;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          // A hung memory completes like a normal response but with zero data.
          if (mem_valid | expired_d) begin
            state_q   <= DONE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (!mem_valid) err_q <= 1'b1;
            if (state_q == BUSY_I) begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= cap_d;
            end else begin
              d_ack_q <= 1'b1;
              if (!mem_we_q) d_rdata_q <= cap_d;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if_ack_q <= 1'b0;
          d_ack_q  <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign if_ack    = if_ack_q;
  assign d_rdata   = d_rdata_q;
  assign d_ack     = d_ack_q;
  assign err       = err_q;
  assign stall     = (if_req & ~if_ack_q) | (d_req & ~d_ack_q);

endmodule
